// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between per-port upstream streams, the arbiter and the single downstream consumer.
// The slave view is taken by the arbiter; the master view is taken by the surrounding sources/sink.
interface stream_rr_arbiter_if #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DATA_SIZE = 16
);
  localparam int unsigned GW = ($clog2(N_PORTS) > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0]           in_valid;
  logic [N_PORTS*DATA_SIZE-1:0] in_data;
  logic [N_PORTS-1:0]           in_ready;
  logic [N_PORTS-1:0]           in_enable;
  logic                         out_valid;
  logic [DATA_SIZE-1:0]         out_data;
  logic                         out_ready;
  logic                         grant_active;
  logic [GW-1:0]                grant_idx;

  modport slave (
    input  in_valid, in_data, in_enable, out_ready,
    output in_ready, out_valid, out_data, grant_active, grant_idx
  );

  modport master (
    output in_valid, in_data, in_enable, out_ready,
    input  in_ready, out_valid, out_data, grant_active, grant_idx
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Burst-limited round-robin arbiter multiplexing N_PORTS valid/ready streams onto one output.
// The granted port is passed through combinationally; arbitration only happens at grant release.
module stream_rr_arbiter #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_rr_arbiter_if.slave   bus
);
  localparam int unsigned GW = ($clog2(N_PORTS) > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CW = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  cnt_q,   cnt_d;

  logic [N_PORTS-1:0] req;
  logic               any_req;
  logic [GW-1:0]      pick;
  logic               pick_found;
  logic [GW-1:0]      cand;

  logic               out_valid_c;
  logic [DATA_SIZE-1:0] out_data_c;
  logic [N_PORTS-1:0] in_ready_c;
  logic               xfer;
  logic               release_c;

  assign req     = bus.in_valid & bus.in_enable;
  assign any_req = |req;

  // Search starts one past the current grant so the current holder is considered last.
  always_comb begin
    pick       = grant_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      cand = GW'((32'(grant_q) + k) % N_PORTS);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    out_valid_c = 1'b0;
    out_data_c  = '0;
    in_ready_c  = '0;
    if (state_q == S_GRANT) begin
      out_valid_c         = bus.in_valid[grant_q];
      in_ready_c[grant_q] = bus.out_ready;
      if (out_valid_c) begin
        out_data_c = bus.in_data[grant_q*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign xfer = out_valid_c & bus.out_ready;

  // A stalled beat (valid without ready) blocks the mask-driven release so the output stays stable.
  assign release_c = (xfer && (cnt_q == CW'(MAX_BURST - 1)))
                   || !bus.in_valid[grant_q]
                   || (!bus.in_enable[grant_q] && !(out_valid_c && !bus.out_ready));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_GRANT;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (release_c) begin
          cnt_d = '0;
          if (any_req) begin
            grant_d = pick;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(xfer);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= GW'(N_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid    = out_valid_c;
  assign bus.out_data     = out_data_c;
  assign bus.in_ready     = in_ready_c;
  assign bus.grant_active = (state_q == S_GRANT);
  assign bus.grant_idx    = grant_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized scoreboard bench for stream_rr_arbiter: stimulus predicts each cycle from a
// transaction-level arbitration model; a negedge monitor pops and compares.
module tb_stream_rr_arbiter;
  localparam int NP = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk;
  logic rst_n;

  stream_rr_arbiter_if #(.N_PORTS(NP), .DATA_SIZE(DW)) bus ();

  stream_rr_arbiter #(.N_PORTS(NP), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          active;
    int          grant;
    bit          valid;
    logic [15:0] data;
    logic [3:0]  rdy;
  } stat_t;

  stat_t       sq[$];
  logic [15:0] bq[$];

  int errors = 0;
  int checks = 0;

  // Reference model state: who owns the output and how many beats it has moved so far.
  bit m_busy;
  int m_owner;
  int m_beats;
  int seq[NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input int from, input logic [3:0] r);
    for (int k = 1; k <= NP; k++) begin
      int c;
      c = (from + k) % NP;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] beat_of(input int p);
    return {2'(p), 14'(seq[p])};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = NP - 1;
    m_beats = 0;
  endtask

  task automatic drive(input int vpct, input int dpct, input int rpct,
                       input logic [3:0] en_fix, input bit en_rand);
    logic [3:0] v;
    v = bus.in_valid;
    for (int p = 0; p < NP; p++) begin
      if (v[p]) begin
        if ($urandom_range(99) < dpct) v[p] = 1'b0;
      end else if ($urandom_range(99) < vpct) begin
        v[p] = 1'b1;
      end
      bus.in_data[p*DW +: DW] = beat_of(p);
    end
    bus.in_valid  = v;
    bus.out_ready = ($urandom_range(99) < rpct);
    bus.in_enable = en_rand ? (4'($urandom) | 4'($urandom)) : en_fix;
  endtask

  // Predicts this cycle's outputs, queues them, then advances the model across the coming edge.
  task automatic model_eval();
    stat_t      s;
    logic [3:0] v, en, r;
    bit         ordy, ev, ex, done;
    int         nxt;
    v    = bus.in_valid;
    en   = bus.in_enable;
    r    = v & en;
    ordy = bus.out_ready;
    ev   = m_busy && v[m_owner];
    ex   = ev && ordy;
    s.active = m_busy;
    s.grant  = m_owner;
    s.valid  = ev;
    s.data   = ev ? beat_of(m_owner) : 16'h0;
    s.rdy    = (m_busy && ordy) ? 4'(1 << m_owner) : 4'h0;
    sq.push_back(s);
    if (ex) begin
      bq.push_back(beat_of(m_owner));
      seq[m_owner]++;
    end
    if (!m_busy) begin
      if (r != 0) begin
        m_busy  = 1'b1;
        m_owner = rr_pick(m_owner, r);
        m_beats = 0;
      end
    end else begin
      done = (ex && (m_beats + 1 == MB)) || !v[m_owner] || (!en[m_owner] && !(ev && !ordy));
      if (done) begin
        m_beats = 0;
        nxt = rr_pick(m_owner, r);
        if (nxt >= 0) m_owner = nxt;
        else          m_busy  = 1'b0;
      end else begin
        m_beats += int'(ex);
      end
    end
  endtask

  task automatic run(input int n, input int vpct, input int dpct, input int rpct,
                     input logic [3:0] en_fix, input bit en_rand);
    repeat (n) begin
      @(posedge clk);
      #1 drive(vpct, dpct, rpct, en_fix, en_rand);
      #1 model_eval();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"},    32'(bus.out_valid),    32'd0);
    chk({tag, "_in_ready"},     32'(bus.in_ready),     32'd0);
    chk({tag, "_grant_active"}, 32'(bus.grant_active), 32'd0);
    chk({tag, "_out_data"},     32'(bus.out_data),     32'd0);
    chk({tag, "_grant_idx"},    32'(bus.grant_idx),    32'(NP - 1));
  endtask

  always begin
    stat_t s;
    @(negedge clk);
    if (rst_n) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL status_queue_empty at %0t", $time);
      end else begin
        s = sq.pop_front();
        chk("grant_active", 32'(bus.grant_active), 32'(s.active));
        chk("grant_idx",    32'(bus.grant_idx),    32'(s.grant));
        chk("out_valid",    32'(bus.out_valid),    32'(s.valid));
        chk("out_data",     32'(bus.out_data),     32'(s.data));
        chk("in_ready",     32'(bus.in_ready),     32'(s.rdy));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat at %0t: got %h expected none", $time, bus.out_data);
        end else begin
          chk("beat_data", 32'(bus.out_data), 32'(bq.pop_front()));
        end
      end
    end
  end

  initial begin
    bit found;
    for (int p = 0; p < NP; p++) seq[p] = p * 1000;
    model_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 4'hF;
    bus.in_enable = 4'hF;
    bus.out_ready = 1'b1;
    for (int p = 0; p < NP; p++) bus.in_data[p*DW +: DW] = beat_of(p);
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");

    // Release, then all ports saturated: expect MB-beat bursts p0,p1,p2,p3,p0 with no gaps.
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(100, 0, 100, 4'hF, 1'b0);
    #1 model_eval();
    run(40, 100, 0, 100, 4'hF, 1'b0);

    run(300, 60, 10, 70, 4'hF, 1'b1);
    run(200, 100, 0, 80, 4'b1010, 1'b0);
    run(200, 70, 5, 20, 4'hF, 1'b1);
    run(100, 50, 30, 90, 4'hF, 1'b0);

    // Async reset mid-burst: wait for a grant with two beats already moved.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_busy && m_beats == 2) begin
        found = 1'b1;
      end else begin
        drive(100, 0, 100, 4'hF, 1'b0);
        #1 model_eval();
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL midburst_search: got no beat_cnt=2 state expected one within 60 cycles");
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    sq.delete();
    bq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(100, 0, 100, 4'hF, 1'b0);
    #1 model_eval();
    @(posedge clk);
    #2 chk("restart_grant_p0", 32'(bus.grant_idx), 32'd0);
    drive(100, 0, 100, 4'hF, 1'b0);
    model_eval();
    run(100, 60, 10, 70, 4'hF, 1'b1);

    @(negedge clk);
    #1;
    chk("beat_queue_drained",   32'(bq.size()), 32'd0);
    chk("status_queue_drained", 32'(sq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
